// File: rtl/alu_seq_md.sv
// alu_seq_md: registered, handshaked RV32I + M-extension ALU for the EX stage.
// Base ops finish in one cycle. MUL*/DIV*/REM* share one radix-2 iterative
// datapath: a shift-add multiplier and a restoring divider, both working on
// operand magnitudes, with the sign fixed up in a final FIX cycle.
// Optional macro ALU_SEQ_FAST_MUL_EN: all multiplies use a combinational
// multiplier and finish in one cycle; divide stays iterative.
module alu_seq_md #(
  parameter int n = 32
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         start,
  input  logic [4:0]   AluOp,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] AluOut
);
  localparam int CW = $clog2(n) + 1;
  localparam int SW = $clog2(n);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q;
  logic [2:0]    op_q;
  logic [n-1:0]  hi_q, lo_q, opnd_q, out_q;
  logic          neg_q, busy_q, done_q;
  logic [CW-1:0] cnt_q;

  // Two's-complement negate when requested (magnitude / sign restore).
  function automatic logic [n-1:0] neg_if(input logic [n-1:0] v, input logic neg);
    if (neg) begin
      neg_if = (~v) + {{(n-1){1'b0}}, 1'b1};
    end else begin
      neg_if = v;
    end
  endfunction

  logic [n-1:0] base_res_d;
  logic [SW-1:0] sh_s;

  // Single-cycle RV32I result for the current request.
  always_comb begin
    sh_s = B[SW-1:0];
    case (AluOp[3:0])
      4'b0000: base_res_d = A + B;
      4'b0001: base_res_d = A - B;
      4'b0010: base_res_d = A << sh_s;
      4'b0100: base_res_d = {{(n-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b0110: base_res_d = {{(n-1){1'b0}}, (A < B)};
      4'b1000: base_res_d = A ^ B;
      4'b1010: base_res_d = A >> sh_s;
      4'b1011: base_res_d = $unsigned($signed(A) >>> sh_s);
      4'b1100: base_res_d = A | B;
      4'b1110: base_res_d = A & B;
      default: base_res_d = {n{1'b0}};
    endcase
  end

  logic         a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, neg_init_d;
  logic [n-1:0] a_mag_d, b_mag_d, special_res_d;
  logic         div_zero_s, div_ovf_s, special_s;

  // Operand signedness, magnitudes and the one-cycle divide special cases.
  always_comb begin
    // signed rs1: MULH(001), MULHSU(010), DIV(100), REM(110)
    if (AluOp[2]) begin
      a_sgn_s = ~AluOp[0];
      b_sgn_s = ~AluOp[0];
    end else begin
      a_sgn_s = (AluOp[1:0] == 2'b01) || (AluOp[1:0] == 2'b10);
      b_sgn_s = (AluOp[1:0] == 2'b01);
    end
    a_neg_s = a_sgn_s & A[n-1];
    b_neg_s = b_sgn_s & B[n-1];
    a_mag_d = neg_if(A, a_neg_s);
    b_mag_d = neg_if(B, b_neg_s);
    // remainder follows the dividend sign; product/quotient the xor of signs
    if (AluOp[2] && AluOp[1]) begin
      neg_init_d = a_neg_s;
    end else begin
      neg_init_d = a_neg_s ^ b_neg_s;
    end
    div_zero_s = (B == {n{1'b0}});
    div_ovf_s  = ~AluOp[0] && (A == {1'b1, {(n-1){1'b0}}}) && (B == {n{1'b1}});
    special_s  = AluOp[2] && (div_zero_s || div_ovf_s);
    if (div_zero_s) begin
      special_res_d = AluOp[1] ? A : {n{1'b1}};
    end else begin
      special_res_d = AluOp[1] ? {n{1'b0}} : A;
    end
  end

`ifdef ALU_SEQ_FAST_MUL_EN
  logic [2*n-1:0] fa_s, fb_s, fast_prod_s;
  logic [n-1:0]   fast_res_d;

  // Combinational multiplier on sign-extended operands.
  always_comb begin
    fa_s        = {{n{a_neg_s}}, A};
    fb_s        = {{n{b_neg_s}}, B};
    fast_prod_s = fa_s * fb_s;
    if (AluOp[1:0] == 2'b00) begin
      fast_res_d = fast_prod_s[n-1:0];
    end else begin
      fast_res_d = fast_prod_s[2*n-1:n];
    end
  end
`endif

  logic [n:0]     sum_s, trial_s;
  logic [n-1:0]   step_hi_d, step_lo_d;

  // One shift-add multiply step or one restoring-divide step.
  always_comb begin
    sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(n+1){1'b0}});
    trial_s = {hi_q, lo_q[n-1]} - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!trial_s[n]) begin
        step_hi_d = trial_s[n-1:0];
        step_lo_d = {lo_q[n-2:0], 1'b1};
      end else begin
        step_hi_d = {hi_q[n-2:0], lo_q[n-1]};
        step_lo_d = {lo_q[n-2:0], 1'b0};
      end
    end else begin
      step_hi_d = sum_s[n:1];
      step_lo_d = {sum_s[0], lo_q[n-1:1]};
    end
  end

  logic [2*n-1:0] prod_fix_s;
  logic [n-1:0]   quo_fix_s, rem_fix_s, fix_res_d;

  // Sign restore and word selection for the FIX cycle.
  always_comb begin
    if (neg_q) begin
      prod_fix_s = (~{hi_q, lo_q}) + {{(2*n-1){1'b0}}, 1'b1};
    end else begin
      prod_fix_s = {hi_q, lo_q};
    end
    quo_fix_s = neg_if(lo_q, neg_q);
    rem_fix_s = neg_if(hi_q, neg_q);
    case (op_q)
      3'b000:                 fix_res_d = prod_fix_s[n-1:0];
      3'b001, 3'b010, 3'b011: fix_res_d = prod_fix_s[2*n-1:n];
      3'b100, 3'b101:         fix_res_d = quo_fix_s;
      3'b110, 3'b111:         fix_res_d = rem_fix_s;
      default:                fix_res_d = {n{1'b0}};
    endcase
  end

  // Control FSM with registered busy/done/result; DONE also accepts a new op.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      hi_q    <= {n{1'b0}};
      lo_q    <= {n{1'b0}};
      opnd_q  <= {n{1'b0}};
      neg_q   <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= {n{1'b0}};
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            if (!AluOp[4]) begin
              out_q   <= base_res_d;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (special_s) begin
              out_q   <= special_res_d;
              done_q  <= 1'b1;
              state_q <= S_DONE;
`ifdef ALU_SEQ_FAST_MUL_EN
            end else if (!AluOp[2]) begin
              out_q   <= fast_res_d;
              done_q  <= 1'b1;
              state_q <= S_DONE;
`endif
            end else begin
              op_q    <= AluOp[2:0];
              neg_q   <= neg_init_d;
              hi_q    <= {n{1'b0}};
              lo_q    <= AluOp[2] ? a_mag_d : b_mag_d;
              opnd_q  <= AluOp[2] ? b_mag_d : a_mag_d;
              cnt_q   <= CW'(n - 1);
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          hi_q <= step_hi_d;
          lo_q <= step_lo_d;
          if (cnt_q == {CW{1'b0}}) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_FIX: begin
          out_q   <= fix_res_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign AluOut = out_q;

endmodule

// File: doc/alu_seq_md.md
Name: alu_seq_md

Overview:
- Registered, handshaked ALU for the RISC-V core: RV32I integer ops plus the M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Base ops complete in one cycle; multiply/divide run on a shared radix-2 iterative datapath.
- Sits in the EX stage; the pipeline stalls on `busy`.

Parameters:
- n, 32, operand/result width (≥8, even).
- CW, $clog2(n)+1, iteration counter width (derived, not overridden).

Ports:
- clock  in  1  system clock, rising edge
- nReset  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- AluOp  in  5  [4]=0: base op (same codes as single-cycle ALU); [4]=1: M-op, [2:0]=funct3
- A  in  n  operand rs1
- B  in  n  operand rs2/imm
- busy  out  1  operation in flight; start ignored while high
- done  out  1  one-cycle pulse, AluOut valid
- AluOut  out  n  result, held until next done

Behaviour:
- Reset (async, nReset=0):
  - state=IDLE; busy=0, done=0, AluOut=0; counter and accumulators cleared.
  - Takes effect mid-operation; the in-flight op is discarded and no done is produced.
- Accept: start=1 && busy=0 at a rising edge latches AluOp, A, B. start with busy=1 is ignored (no queueing).
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE→DONE: base op, or M-op special case (div-by-zero / overflow).
  - IDLE→RUN: M-op; counter=n-1.
  - RUN: one partial product / restoring-division step per cycle. Counter 0 → FIX.
  - FIX: sign correction (negate result for signed ops as needed); selects high/low product word or quotient/remainder. → DONE.
  - DONE: done=1 for exactly one cycle, busy=0, → IDLE. A new start is accepted in that same cycle.
- busy=1 in RUN and FIX.
- Latency, with start sampled at edge 0:
  - base ops: done at edge 1.
  - M-ops: done at edge n+2 (34 for n=32).
- Base ops (AluOp[4]=0):
  - ADD 0000, SUB 0001, SLL 0010, SLT 0100 (signed), SLTU 0110 (true unsigned compare), XOR 1000, SRL 1010, SRA 1011 (arithmetic), OR 1100, AND 1110.
  - Shift amount = B[$clog2(n)-1:0] only; upper bits ignored.
  - Undefined codes → AluOut=0, done still pulses.
- Mul: 2n-bit product computed on operand magnitudes.
  - MUL: low n bits.
  - MULH: high n bits, signed×signed.
  - MULHSU: high n bits, signed A × unsigned B.
  - MULHU: high n bits, unsigned×unsigned.
- Div/rem:
  - Truncating toward zero; remainder takes the sign of the dividend.
  - B=0: DIV/DIVU → all ones; REM/REMU → A. 1-cycle path.
  - Signed overflow (A=100…0, B=all ones): DIV → A; REM → 0. 1-cycle path.
- Results are truncated to n bits; no flags or exceptions.
- Operand inputs may change after acceptance without affecting the result.

Optional Feature:
- Macro: ALU_SEQ_FAST_MUL_EN.
- Defined:
  - All four MUL variants use a combinational n×n signed-extended multiplier.
  - Path is IDLE→DONE, done at edge 1.
  - Divide remains iterative.
- Undefined:
  - Multiply is iterative, done at edge n+2.
  - No multiplier inferred.

Test Plan:
- Reset mid-op: start DIV 100/7, pull nReset low at edge 10 → busy=0, done=0, AluOut=0 immediately. After release, no done pulse.
- SLTU vs SLT: A=0xFFFF_FFFF, B=1 → SLTU=0, SLT=1. SRA 0x8000_0000 by B=0x24 (shift 4) → 0xF800_0000. Each done at edge 1.
- MUL family: A=0xFFFF_FFFE (-2), B=3 → MUL=0xFFFF_FFFA, MULH=0xFFFF_FFFF, MULHU=0x0000_0002, MULHSU=0xFFFF_FFFF. done at edge 34 (edge 1 with ALU_SEQ_FAST_MUL_EN).
- Division signs: DIV -7/2 → 0xFFFF_FFFD; REM -7/2 → 0xFFFF_FFFF; DIVU 0xFFFF_FFF9/2 → 0x7FFF_FFFC. done at edge 34.
- Specials: DIV 5/0 → 0xFFFF_FFFF; REMU 5/0 → 5; DIV 0x8000_0000/-1 → 0x8000_0000; REM of same → 0. Each done at edge 1.
- Back-to-back/ignore: start held high continuously with alternating ADD 2+3 and MUL 6×7.
  - start pulses while busy are ignored.
  - A new op is accepted in the DONE cycle.
  - Exactly one done per accepted op; results 5, 42 in order.
